// File: rtl/ppu_pkg.sv
// Shared types for the ppu table write queue.
// Region select enum, control bit positions, queued entry layout.
package ppu_pkg;

  typedef enum logic [1:0] {
    TBL_ATTR   = 2'b00,
    TBL_SPRITE = 2'b01,
    TBL_COLOR  = 2'b10,
    REG_CTRL   = 2'b11
  } tbl_sel_e;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;

  typedef struct packed {
    tbl_sel_e    sel;
    logic [7:0]  addr;
    logic [31:0] data;
  } wq_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } wq_state_e;

  function automatic logic [2:0] sel_onehot(
    input tbl_sel_e s
  );
    logic [2:0] oh;
    oh = 3'b000;
    case (s)
      TBL_ATTR:   oh = 3'b001;
      TBL_SPRITE: oh = 3'b010;
      TBL_COLOR:  oh = 3'b100;
      default:    oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/wq_fifo.sv
// Entry storage for the write queue: wr/rd pointers with a wrap bit.
// Ports: push/push_data, pop/rd_data, rewind loads wr_ptr from rewind_ptr.
module wq_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wq_entry_t              push_data,
  input  logic                   pop,
  input  logic                   rewind,
  input  logic [$clog2(DEPTH):0] rewind_ptr,
  output logic [$clog2(DEPTH):0] wr_ptr,
  output logic [$clog2(DEPTH):0] rd_ptr,
  output wq_entry_t              rd_data
);

  localparam int AW = $clog2(DEPTH);

  wq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (rewind) begin
        wr_ptr <= rewind_ptr;
      end else if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ppu_write_queue.sv
// Buffers CPU table writes; drains committed ones only in vblank.
// Ports: Avalon slave in, vblank in, one-hot table write port, status out.
module ppu_write_queue
  import ppu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic [15:0]       address,
  input  logic [DATA_W-1:0] writedata,
  output logic              waitrequest,
  input  logic              vblank,
  output logic [2:0]        tbl_we,
  output logic [7:0]        tbl_addr,
  output logic [DATA_W-1:0] tbl_data,
  output logic [CNT_W-1:0]  level,
  output logic [CNT_W-1:0]  pending,
  output logic              busy
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] cm_ptr;
  logic [PW-1:0] cm_next;
  logic [PW-1:0] rd_next;
  logic [PW-1:0] level_w;
  logic [PW-1:0] pend_w;
  logic [PW-1:0] pend_next;

  tbl_sel_e  region;
  wq_entry_t push_data;
  wq_entry_t rd_data;
  wq_state_e state_q;
  wq_state_e state_d;

  logic bus_wr;
  logic is_ctrl;
  logic full;
  logic push;
  logic pop;
  logic ctrl_wr;
  logic commit;
  logic flush;
  logic vblank_q;
  logic vblank_rise;
  logic unused_addr;

  assign unused_addr = ^address[15:10];

  assign region  = tbl_sel_e'(address[9:8]);
  assign bus_wr  = chipselect & write;
  assign is_ctrl = (region == REG_CTRL);

  assign level_w = wr_ptr - rd_ptr;
  assign pend_w  = cm_ptr - rd_ptr;
  assign full    = (level_w == PW'(DEPTH));

  assign waitrequest = bus_wr & ~is_ctrl & full;
  assign push        = bus_wr & ~is_ctrl & ~full;

  assign ctrl_wr = bus_wr & is_ctrl
                 & (address[7:0] == 8'h00);
  assign commit  = ctrl_wr
                 & writedata[CTRL_COMMIT_BIT];
  // Commit takes priority over flush.
  assign flush   = ctrl_wr & ~commit
                 & writedata[CTRL_FLUSH_BIT];

  assign push_data = '{
    sel:  region,
    addr: address[7:0],
    data: 32'(writedata)
  };

  wq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .rewind     (flush),
    .rewind_ptr (cm_ptr),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .rd_data    (rd_data)
  );

  assign vblank_rise = vblank & ~vblank_q;

  assign pop = (state_q == ST_DRAIN)
             & vblank & (pend_w != '0);

  assign rd_next   = rd_ptr + PW'(pop);
  assign cm_next   = commit ? wr_ptr : cm_ptr;
  // Look ahead so a same-cycle commit keeps DRAIN alive.
  assign pend_next = cm_next - rd_next;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (vblank_rise && pend_w != '0) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!vblank || pend_next == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      vblank_q <= 1'b0;
      cm_ptr   <= '0;
    end else begin
      state_q  <= state_d;
      vblank_q <= vblank;
      cm_ptr   <= cm_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_we   <= '0;
      tbl_addr <= '0;
      tbl_data <= '0;
    end else begin
      tbl_we <= pop ? sel_onehot(rd_data.sel) : 3'b000;
      if (pop) begin
        tbl_addr <= rd_data.addr;
        tbl_data <= DATA_W'(rd_data.data);
      end
    end
  end

  assign level   = CNT_W'(level_w);
  assign pending = CNT_W'(pend_w);
  assign busy    = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_ppu_write_queue.sv
// Directed bench for ppu_write_queue.
// Drives the Avalon slave and vblank, checks the table write port.
module tb_ppu_write_queue;

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic [15:0] address;
  logic [31:0] writedata;
  logic        waitrequest;
  logic        vblank;
  logic [2:0]  tbl_we;
  logic [7:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic [4:0]  level;
  logic [4:0]  pending;
  logic        busy;

  int n_vec;
  int n_bad;

  logic [42:0] capq [$];

  ppu_write_queue #(
    .DEPTH  (16),
    .DATA_W (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .address     (address),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .vblank      (vblank),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .level       (level),
    .pending     (pending),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic bus_wr(
    input logic [15:0] a,
    input logic [31:0] d
  );
    @(negedge clk);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic cap(input int hi, input int tail);
    capq.delete();
    @(negedge clk);
    vblank = 1'b1;
    for (int i = 0; i < hi + tail; i++) begin
      @(negedge clk);
      if (tbl_we != 3'b000)
        capq.push_back({tbl_we, tbl_addr, tbl_data});
      if (i == hi - 1) vblank = 1'b0;
    end
  endtask

  initial begin
    logic [2:0] seen;
    int         acc;
    int         acc_i;

    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    chipselect = 1'b0;
    write = 1'b0;
    address = '0;
    writedata = '0;
    vblank = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_we", tbl_we, 3'b000);
    check("rst_addr", tbl_addr, 8'h00);
    check("rst_data", tbl_data, 32'h0);
    check("rst_level", level, 5'd0);
    check("rst_pend", pending, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_wait", waitrequest, 1'b0);
    reset = 1'b0;

    // basic commit with exact latency
    bus_wr(16'h0003, 32'hDEADBEEF);
    bus_wr(16'h0105, 32'h12345678);
    check("b_lvl_pre", level, 5'd2);
    check("b_pend_pre", pending, 5'd0);
    bus_wr(16'h0300, 32'h1);
    check("b_pend", pending, 5'd2);
    @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    check("b_t1_busy", busy, 1'b1);
    check("b_t1_we", tbl_we, 3'b000);
    @(negedge clk);
    check("b_t2_we", tbl_we, 3'b001);
    check("b_t2_addr", tbl_addr, 8'h03);
    check("b_t2_data", tbl_data, 32'hDEADBEEF);
    @(negedge clk);
    check("b_t3_we", tbl_we, 3'b010);
    check("b_t3_addr", tbl_addr, 8'h05);
    check("b_t3_data", tbl_data, 32'h12345678);
    @(negedge clk);
    check("b_t4_we", tbl_we, 3'b000);
    check("b_t4_hold", tbl_addr, 8'h05);
    check("b_t4_pend", pending, 5'd0);
    check("b_t4_busy", busy, 1'b0);
    vblank = 1'b0;
    @(negedge clk);
    check("b_lvl", level, 5'd0);

    // uncommitted writes are gated
    bus_wr(16'h0010, 32'h1);
    bus_wr(16'h0111, 32'h2);
    bus_wr(16'h0212, 32'h3);
    cap(4, 2);
    check("g_cnt", capq.size(), 0);
    check("g_lvl", level, 5'd3);
    check("g_pend", pending, 5'd0);
    bus_wr(16'h0300, 32'h2);
    check("g_flush", level, 5'd0);
    bus_wr(16'h0300, 32'h1);
    check("g_noop_p", pending, 5'd0);
    check("g_noop_l", level, 5'd0);

    // flush drops only uncommitted entries
    bus_wr(16'h0020, 32'hA1);
    bus_wr(16'h0121, 32'hB1);
    bus_wr(16'h0300, 32'h1);
    bus_wr(16'h0222, 32'hC1);
    bus_wr(16'h0023, 32'hD1);
    bus_wr(16'h0300, 32'h2);
    check("f_lvl", level, 5'd2);
    check("f_pend", pending, 5'd2);
    cap(6, 2);
    check("f_cnt", capq.size(), 2);
    check("f_e0", capq[0], {3'b001, 8'h20, 32'hA1});
    check("f_e1", capq[1], {3'b010, 8'h21, 32'hB1});
    check("f_lvl_end", level, 5'd0);

    // bad offset ignored, both bits: commit wins
    bus_wr(16'h0030, 32'h5);
    bus_wr(16'h0031, 32'h6);
    bus_wr(16'h0301, 32'h1);
    check("o_pend", pending, 5'd0);
    bus_wr(16'h0300, 32'h3);
    check("o_both_p", pending, 5'd2);
    check("o_both_l", level, 5'd2);
    bus_wr(16'h0300, 32'h2);
    check("o_flush_l", level, 5'd2);
    cap(6, 2);
    check("o_cnt", capq.size(), 2);
    check("o_lvl", level, 5'd0);

    // full queue stalls data, not control
    for (int i = 0; i < 16; i++)
      bus_wr(16'h0200 + 16'(i), 32'h100 + 32'(i));
    check("u_lvl", level, 5'd16);
    @(negedge clk);
    chipselect = 1'b1;
    write = 1'b1;
    address = 16'h0240;
    writedata = 32'h999;
    #1;
    check("u_wait", waitrequest, 1'b1);
    repeat (2) @(negedge clk);
    check("u_wait_hold", waitrequest, 1'b1);
    check("u_lvl_hold", level, 5'd16);
    @(negedge clk);
    address = 16'h0300;
    writedata = 32'h1;
    #1;
    check("u_ctrl_wait", waitrequest, 1'b0);
    @(posedge clk);
    #1;
    address = 16'h0240;
    writedata = 32'h999;
    check("u_pend", pending, 5'd16);
    capq.delete();
    acc = 0;
    acc_i = -1;
    @(negedge clk);
    vblank = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (chipselect && acc != 0) begin
        chipselect = 1'b0;
        write = 1'b0;
      end
      if (tbl_we != 3'b000)
        capq.push_back({tbl_we, tbl_addr, tbl_data});
      if (chipselect && acc == 0) begin
        #1;
        if (!waitrequest) begin
          acc = 1;
          acc_i = i;
        end
      end
    end
    vblank = 1'b0;
    chipselect = 1'b0;
    write = 1'b0;
    check("u_acc", acc, 1);
    check("u_acc_cyc", acc_i, 1);
    check("u_cnt", capq.size(), 16);
    check("u_first", capq[0], {3'b100, 8'h00, 32'h100});
    check("u_last", capq[15], {3'b100, 8'h0F, 32'h10F});
    check("u_lvl_end", level, 5'd1);
    check("u_pend_end", pending, 5'd0);
    bus_wr(16'h0300, 32'h2);
    check("u_clear", level, 5'd0);

    // short vblank splits the drain
    for (int i = 0; i < 10; i++)
      bus_wr(16'(i), 32'hA0 + 32'(i));
    bus_wr(16'h0300, 32'h1);
    cap(5, 3);
    check("s_cnt1", capq.size(), 4);
    for (int i = 0; i < 4; i++)
      check("s_a", capq[i],
            {3'b001, 8'(i), 32'hA0 + 32'(i)});
    check("s_pend", pending, 5'd6);
    check("s_busy", busy, 1'b0);
    cap(12, 3);
    check("s_cnt2", capq.size(), 6);
    for (int i = 0; i < 6; i++)
      check("s_b", capq[i],
            {3'b001, 8'(4 + i), 32'hA4 + 32'(i)});
    check("s_lvl", level, 5'd0);

    // async reset in the middle of a drain
    for (int i = 0; i < 5; i++)
      bus_wr(16'h0040 + 16'(i), 32'h50 + 32'(i));
    bus_wr(16'h0300, 32'h1);
    @(negedge clk);
    vblank = 1'b1;
    repeat (4) @(negedge clk);
    check("r_third_we", tbl_we, 3'b001);
    check("r_third_a", tbl_addr, 8'h42);
    reset = 1'b1;
    #1;
    check("r_we", tbl_we, 3'b000);
    check("r_lvl", level, 5'd0);
    check("r_pend", pending, 5'd0);
    check("r_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    seen = 3'b000;
    repeat (6) begin
      @(negedge clk);
      seen = seen | tbl_we;
    end
    check("r_quiet", seen, 3'b000);
    check("r_lvl_end", level, 5'd0);
    vblank = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ppu_write_queue.md
Name: ppu_write_queue

Overview:
Sits directly upstream of the ppu table write port, between the Avalon-MM slave bus and the attribute, sprite and colour tables. It buffers CPU table writes in a FIFO. Writes are released only after software issues a commit, and only during vertical blank, so the tables never change mid-frame (no tearing). The drained stream becomes the ppu's one-hot table write enable, address and data.

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 2.
- DATA_W, 32: table word width.
- CNT_W, $clog2(DEPTH+1): width of the level and pending counters.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- address  in  16  Avalon word address; [9:8] selects the region, [7:0] is the table offset.
- writedata  in  DATA_W  Avalon write data.
- waitrequest  out  1  stalls a data-region write while the FIFO is full.
- vblank  in  1  level, high during vertical blank; driven synchronously from vcount.
- tbl_we  out  3  one-hot: [0] attr, [1] sprite, [2] colour.
- tbl_addr  out  8  table address.
- tbl_data  out  DATA_W  table word.
- level  out  CNT_W  total queued entries.
- pending  out  CNT_W  committed entries not yet drained.
- busy  out  1  high while in DRAIN.

Behaviour:
- Reset values: tbl_we=0, tbl_addr=0, tbl_data=0, level=0, pending=0, busy=0, waitrequest=0. Pointers zero, state IDLE, vblank_q=0.
- Region decode on address[9:8]:
  - 00, 01, 10 are data writes; push {sel, address[7:0], writedata}.
  - 11 is control, offset 0x00 only.
    - writedata[0]=1 commits: the commit boundary moves to the write pointer.
    - writedata[1]=1 flushes: the write pointer moves back to the commit boundary, discarding uncommitted entries.
    - Both bits set: commit wins, flush is ignored.
    - Other offsets are ignored.
- waitrequest is combinational: chipselect & write & (address[9:8]!=2'b11) & (level==DEPTH). Control writes are never stalled.
- A data write is accepted on a cycle where chipselect & write & !waitrequest. level increments the next cycle.
- pending is the number of entries between the read pointer and the commit boundary. It is always ≤ level.
- Edge detect: vblank_q <= vblank every cycle; vblank_rise = vblank & !vblank_q.
- FSM IDLE:
  - On vblank_rise with pending>0 (the value before any same-cycle commit), go to DRAIN.
  - Otherwise stay in IDLE.
- FSM DRAIN:
  - Each cycle with vblank=1 and pending>0, pop one entry.
  - The popped entry drives registered tbl_we (one-hot from sel), tbl_addr and tbl_data the next cycle; tbl_we stays high for exactly one cycle per entry.
  - Leave to IDLE when pending reaches 0 or vblank drops. Remaining committed entries wait for the next vblank_rise.
- Latency: the vblank_rise sample cycle is T. The state is DRAIN from T+1. The first tbl_we is high at T+2. Throughput is one entry per cycle after that.
- tbl_addr and tbl_data hold their last value when tbl_we=0.
- Simultaneous push and pop: level is unchanged. Pointers wrap modulo DEPTH.
- A commit during DRAIN extends the boundary. Newly committed entries drain in the same vblank if vblank is still high.
- A flush never removes committed or in-flight entries.
- A commit with no uncommitted entries is a no-op.
- A data write in the same cycle as a control write is impossible: it is a single bus.
- An asynchronous reset mid-DRAIN clears everything immediately. Partially drained contents are lost.
- busy = (state==DRAIN).

Decomposition:
- ppu_pkg holds:
  - the enum tbl_sel_e: TBL_ATTR=2'b00, TBL_SPRITE=2'b01, TBL_COLOR=2'b10, REG_CTRL=2'b11;
  - CTRL_COMMIT_BIT=0 and CTRL_FLUSH_BIT=1;
  - the packed struct wq_entry_t {tbl_sel_e sel; logic [7:0] addr; logic [31:0] data}.
- Sub-module wq_fifo: storage array of wq_entry_t with wr_ptr, rd_ptr, push, pop, and a rewind input that loads wr_ptr from a given value (used for flush). It has no commit knowledge.
- Commit pointer, FSM and output registers stay in ppu_write_queue.

Test Plan:
- Basic commit: write attr@0x0003=0xDEADBEEF and sprite@0x0105=0x12345678, commit, then raise vblank at cycle T.
  - tbl_we=001/addr 0x03/data DEADBEEF at T+2.
  - tbl_we=010/addr 0x05/data 12345678 at T+3.
  - pending=0 and busy=0 afterwards.
- Gating: 3 writes without commit, then a vblank pulse → no tbl_we, level=3, pending=0.
- Flush: 2 writes, commit, 2 more writes, control write 0x2 → level=2. The next vblank drains only the first 2 entries.
- Full: 16 writes then a 17th → waitrequest=1 on the 17th until a drain pops one entry. A control commit during full is accepted with no stall.
- Short vblank: commit 10 entries, vblank high for 5 cycles → 4 entries drained (T+2..T+5), pending=6. The next vblank drains the remaining 6 in order.
- Reset mid-DRAIN: assert reset during the 3rd output → tbl_we=0, level=0, pending=0 immediately. No writes after reset is released.
